// File: rtl/ahb_lite_master.sv
// Command-driven AHB-Lite single-transfer master: one command at a time is turned into an
// address phase and a data phase, then a one-cycle response carries read data and status.
module ahb_lite_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8,
  parameter logic [3:0]  HPROT_DEF      = 4'b0001
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  logic [1:0]       r_state;
  logic             r_wr;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_hsel;
  logic [31:0]      r_haddr;
  logic [1:0]       r_htrans;
  logic             r_hwrite;
  logic [2:0]       r_hsize;
  logic [3:0]       r_hprot;
  logic [31:0]      r_hwdata;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_rsp_timeout;

  logic             w_size_ok;
  logic [2:0]       w_hsize;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic             w_hresp_err;

  always_comb begin
    w_size_ok = 1'b1;
    w_hsize   = 3'b000;
    case (cmd_size)
      3'd1:    w_hsize = 3'b000;
      3'd2:    w_hsize = 3'b001;
      3'd4:    w_hsize = 3'b010;
      default: w_size_ok = 1'b0;
    endcase
  end

  // Counter saturates so a disabled timeout never wraps into a false match.
  assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
  assign w_hresp_err = (HRESP == 2'b01);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state       <= StIdle;
      r_wr          <= 1'b0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
      r_hsel        <= 1'b0;
      r_haddr       <= '0;
      r_htrans      <= HtransIdle;
      r_hwrite      <= 1'b0;
      r_hsize       <= '0;
      r_hprot       <= '0;
      r_hwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            if (w_size_ok) begin
              r_state  <= StAddr;
              r_wr     <= cmd_write;
              r_wdata  <= cmd_wdata;
              r_hsel   <= 1'b1;
              r_htrans <= HtransNonseq;
              r_haddr  <= cmd_addr;
              r_hwrite <= cmd_write;
              r_hsize  <= w_hsize;
              r_hprot  <= HPROT_DEF;
            end else begin
              // Illegal size: answer immediately without touching the bus.
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        StAddr: begin
          if (HREADY) begin
            r_state  <= StData;
            r_htrans <= HtransIdle;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_hsize  <= '0;
            r_hprot  <= '0;
            r_hwdata <= r_wr ? r_wdata : '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
          end
        end
        StData: begin
          if (HREADY) begin
            r_state     <= StResp;
            r_hsel      <= 1'b0;
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err | w_hresp_err;
            r_rsp_rdata <= r_wr ? '0 : HRDATA;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_hresp_err) r_err <= 1'b1;
            if (w_timeout) begin
              r_state       <= StResp;
              r_hsel        <= 1'b0;
              r_hwdata      <= '0;
              r_rsp_valid   <= 1'b1;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b1;
            end
          end
        end
        StResp: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = (r_state == StIdle);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign HSEL        = r_hsel;
  assign HADDR       = r_haddr;
  assign HTRANS      = r_htrans;
  assign HWRITE      = r_hwrite;
  assign HSIZE       = r_hsize;
  assign HBURST      = 3'b000;
  assign HPROT       = r_hprot;
  assign HMASTLOCK   = 1'b0;
  assign HWDATA      = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: a slave model shapes HREADY/HRESP per command, expected responses
// are queued at accept time and a separate monitor checks each rsp_valid pulse against them.
`timescale 1ns/1ps
module tb_ahb_lite_master;

  localparam int T = 4;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [2:0]  cmd_size = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP = 2'b00;
  logic [31:0] HRDATA = '0;

  ahb_lite_master #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (8),
    .HPROT_DEF     (4'b0001)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_size   (cmd_size),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HMASTLOCK  (HMASTLOCK),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge HCLK) begin
    if (!HRESET && rsp_valid) begin
      if (q.size() == 0) begin
        check("spurious_rsp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_HSEL"}, 32'(HSEL), 0);
    check({tag, "_HTRANS"}, 32'(HTRANS), 0);
    check({tag, "_HADDR"}, HADDR, 0);
    check({tag, "_HWRITE"}, 32'(HWRITE), 0);
    check({tag, "_HSIZE"}, 32'(HSIZE), 0);
    check({tag, "_HPROT"}, 32'(HPROT), 0);
    check({tag, "_HWDATA"}, HWDATA, 0);
    check({tag, "_HBURST"}, 32'(HBURST), 0);
    check({tag, "_HMASTLOCK"}, 32'(HMASTLOCK), 0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 0);
    check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
  endtask

  // Called at a negedge with the master idle. aw = address-phase waits, nw = data-phase waits,
  // werr = ERROR signalled on the first data wait, ferr = ERROR on the completing edge.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, input int aw, input int nw, input bit werr,
                         input bit ferr, input logic [31:0] rd);
    exp_t e;
    bit   ok;
    bit   to;
    int   i;
    ok = (size == 3'd1) || (size == 3'd2) || (size == 3'd4);
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_size  = size;
    HREADY    = 1'b1;
    HRESP     = 2'b00;
    if (!ok) begin
      e.rdata = '0; e.err = 1'b1; e.to = 1'b0; e.cyc = cyc + 1;
      q.push_back(e);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      check("badsize_HTRANS", 32'(HTRANS), 0);
      check("badsize_HSEL", 32'(HSEL), 0);
      check("badsize_cmd_ready", 32'(cmd_ready), 1);
      return;
    end
    to      = (nw >= T);
    e.to    = to;
    e.err   = to | (werr && nw > 0) | ferr;
    e.rdata = (!wr && !to) ? rd : 32'd0;
    e.cyc   = cyc + (to ? 2 + aw + T : 3 + aw + nw);
    q.push_back(e);
    // Address phase; cmd_* carries garbage from here on and must be ignored.
    for (int a = 0; a <= aw; a++) begin
      @(negedge HCLK);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_write = 1'($urandom);
      cmd_size  = 3'd4;
      HREADY    = (a == aw);
      check("addr_HTRANS", 32'(HTRANS), 32'h2);
      check("addr_HSEL", 32'(HSEL), 1);
      check("addr_HADDR", HADDR, addr);
      check("addr_HWRITE", 32'(HWRITE), 32'(wr));
      check("addr_HSIZE", 32'(HSIZE), 32'($clog2(int'(size))));
      check("addr_HPROT", 32'(HPROT), 32'h1);
      check("addr_cmd_ready", 32'(cmd_ready), 0);
    end
    i = 0;
    forever begin
      @(negedge HCLK);
      if (i == 0) begin
        check("data_HTRANS", 32'(HTRANS), 0);
        check("data_HADDR", HADDR, 0);
        check("data_HPROT", 32'(HPROT), 0);
        check("data_HSEL", 32'(HSEL), 1);
        check("data_HWDATA", HWDATA, wr ? wdata : 32'd0);
      end
      if (i < nw) begin
        HREADY = 1'b0;
        HRESP  = (werr && i == 0) ? 2'b01 : 2'b00;
        HRDATA = $urandom;
        i++;
        if (i == T) break;
      end else begin
        HREADY = 1'b1;
        HRESP  = ferr ? 2'b01 : 2'b00;
        HRDATA = rd;
        break;
      end
    end
    @(negedge HCLK);
    HREADY = 1'b1;
    HRESP  = 2'b00;
    check("resp_HSEL", 32'(HSEL), 0);
    check("resp_HWDATA", HWDATA, 0);
    check("resp_cmd_ready", 32'(cmd_ready), 0);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("post_HTRANS", 32'(HTRANS), 0);
  endtask

  initial begin
    logic [2:0] bad_sizes[5];
    bad_sizes = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd7};
    repeat (3) @(negedge HCLK);
    check_reset_vals("reset");
    HRESET = 1'b0;
    @(negedge HCLK);
    check_reset_vals("idle");

    // Directed cases
    run_cmd(1'b1, 32'h8C00_0000, 32'h0038_0000, 3'd4, 0, 0, 1'b0, 1'b0, 32'h0);
    run_cmd(1'b0, 32'h8C00_0004, 32'h0, 3'd4, 0, 2, 1'b0, 1'b0, 32'h0003_1AAD);
    run_cmd(1'b1, 32'h8C00_0001, 32'h1234_5678, 3'd1, 0, 1, 1'b1, 1'b1, 32'h0);
    run_cmd(1'b0, 32'h8C00_0008, 32'h0, 3'd2, 0, 10, 1'b0, 1'b0, 32'hDEAD_BEEF);
    run_cmd(1'b1, 32'h8C00_000C, 32'hFFFF_FFFF, 3'd3, 0, 0, 1'b0, 1'b0, 32'h0);
    run_cmd(1'b0, 32'h8C00_0010, 32'h0, 3'd4, 2, 1, 1'b0, 1'b1, 32'hA5A5_5A5A);

    // Reset during a read data phase: no response, outputs cleared at once
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8C00_0020; cmd_size = 3'd4;
    HREADY = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    HREADY = 1'b0;
    check("rst_mid_HSEL_before", 32'(HSEL), 1);
    #2 HRESET = 1'b1;
    #1 check_reset_vals("rst_mid");
    @(negedge HCLK);
    HRESET = 1'b0;
    HREADY = 1'b1;
    repeat (2) @(negedge HCLK);
    run_cmd(1'b1, 32'h8C00_0000, 32'h0038_0000, 3'd4, 0, 0, 1'b0, 1'b0, 32'h0);

    // Randomised commands
    for (int n = 0; n < 40; n++) begin
      int          r;
      logic [2:0]  sz;
      r = int'($urandom_range(0, 9));
      sz = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : (r < 9) ? 3'd4 : bad_sizes[$urandom_range(0, 4)];
      run_cmd(1'($urandom), $urandom, $urandom, sz, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), $urandom);
    end

    repeat (4) @(negedge HCLK);
    check("pending_rsp", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Command-driven AHB-Lite single-transfer master. It sits directly upstream of the AHB2APB bridge and drives its HTRANS/HADDR/HWRITE/HWDATA/HSELAPBif inputs.
- It converts one-at-a-time read/write commands into address and data phases, then returns read data and an error/timeout status.
- It replaces bench-level bus tasks so that a CPU-side controller or a sequencer can reach the APB/CORDIC slaves.

Parameters:
TIMEOUT_CYCLES, 255, data-phase cycles with HREADY low before abort; 0 disables the timeout
CNT_W, 8, width of the wait-state counter; must hold TIMEOUT_CYCLES
HPROT_DEF, 4'b0001, HPROT driven during the address phase (data access)

Ports:
HCLK  in  1  bus clock; all logic is rising-edge.
HRESET  in  1  reset, asynchronous and active-high (one clock; reset is asynchronous and active-high).
cmd_valid  in  1  command request.
cmd_ready  out  1  master can accept a command (high only in IDLE).
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  32  transfer address.
cmd_wdata  in  32  write data.
cmd_size  in  3  bytes per transfer: 1, 2 or 4.
rsp_valid  out  1  one-cycle pulse when the command completes.
rsp_rdata  out  32  captured HRDATA; valid with rsp_valid on reads, else 0.
rsp_err  out  1  qualified by rsp_valid: ERROR response, timeout, or bad size.
rsp_timeout  out  1  qualified by rsp_valid: abort caused by the timeout.
HSEL  out  1  slave select for the bridge (HSELAPBif).
HADDR  out  32  address.
HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
HWRITE  out  1  direction.
HSIZE  out  3  000 / 001 / 010.
HBURST  out  3  always 000 (SINGLE).
HPROT  out  4  HPROT_DEF in the address phase, else 0000.
HMASTLOCK  out  1  always 0.
HWDATA  out  32  write data, driven in the data phase.
HREADY  in  1  bridge HREADYout; the system also ties bridge HREADYin to this signal.
HRESP  in  2  00 = OKAY, 01 = ERROR.
HRDATA  in  32  read data.

Behaviour:
- Reset (asynchronous, any state): state = IDLE.
  - Outputs: HTRANS = 00, HSEL = 0, HADDR = 0, HWRITE = 0, HSIZE = 0, HBURST = 0, HPROT = 0, HMASTLOCK = 0, HWDATA = 0.
  - cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0, wait counter = 0.
- All AHB outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - cmd_valid & cmd_ready with cmd_size in {1, 2, 4}: latch the command and go to ADDR. The next cycle drives HSEL = 1, HTRANS = 10, HADDR, HWRITE, HSIZE and HPROT.
  - cmd_size not in {1, 2, 4}: no bus activity; pulse rsp_valid with rsp_err = 1 on the next cycle; stay in IDLE.
- ADDR:
  - Hold all address-phase signals until a rising edge with HREADY = 1.
  - At that edge, go to DATA:
    - HTRANS = 00, HADDR = 0, HPROT = 0, HWRITE = 0, HSIZE = 0.
    - HWDATA = latched wdata on writes, 0 on reads.
    - HSEL stays 1.
  - The wait counter does not run in ADDR.
- DATA:
  - Each edge with HREADY = 0 increments the counter and records a sticky error if HRESP = 01.
  - Edge with HREADY = 1: capture HRDATA (reads only). rsp_err = sticky error | (HRESP == 01). Go to RESP.
  - Counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0) with HREADY still 0: go to RESP with rsp_err = 1 and rsp_timeout = 1. Read data is 0. HSEL is dropped.
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - HSEL = 0, HWDATA = 0, counter cleared.
  - Go to IDLE.
  - Minimum command-to-command spacing is 4 cycles, because there is no pipelining: an IDLE cycle always separates transfers.
- Latency: with zero wait states, rsp_valid rises 3 cycles after cmd accept. Each wait state adds 1 cycle.
- cmd_* inputs are ignored outside IDLE. A new command cannot be accepted in the RESP cycle.
- HRESP = 01 together with HREADY = 1 on a single edge is also reported as an error.
- HRESET asserted mid-transfer aborts it immediately. No rsp_valid is issued.

Test Plan:
1. Write, zero wait: cmd 0x8C00_0000, wdata 0x0038_0000, size 4 -> HTRANS = 10 / HSIZE = 010 for one cycle; next cycle HWDATA = 0x0038_0000 and HTRANS = 00; rsp_valid 3 cycles after accept, rsp_err = 0.
2. Read, 2 wait states (bridge holds HREADY low for 2 cycles, HRDATA = 0x0003_1AAD) -> rsp_valid at accept + 5, rsp_rdata = 0x0003_1AAD, rsp_err = 0.
3. Error: slave returns HRESP = 01 with HREADY = 0, then HRESP = 01 with HREADY = 1 on a write to 0x8C00_0001 -> rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
4. Timeout: TIMEOUT_CYCLES = 4, HREADY held low -> rsp_valid after 4 data-phase wait cycles, rsp_err = 1, rsp_timeout = 1, HSEL = 0 afterwards.
5. Bad size: cmd_size = 3 -> HTRANS stays 00 and HSEL stays 0; rsp_valid next cycle with rsp_err = 1.
6. Reset mid-read: assert HRESET during DATA -> outputs immediately at reset values, no rsp_valid; after release, a write to 0x8C00_0000 completes normally.
